seq_gen_01110: RTL and testbench
================================

# seq_gen_01110

Pattern transmitter for the 2-bit-per-clock A/B symbol interface consumed by `seq_detect_01110`. The block loads a SEQUENCE_WIDTH-bit pattern and emits it as {A,B} pairs, most significant pair first, for a programmable number of passes. In parallel it keeps a golden count of `01110` occurrences in the emitted bit stream, so a bench or self-test wrapper can check the detector against it. It sits between the stimulus/control logic and the detector's A/B inputs.

## Interface
- SEQUENCE_WIDTH, 24, pattern length in bits; even, ≥ 2
- REPEAT_W, 4, width of repeat_n
- CNT_W, 8, width of match_cnt
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- seq_in  in  SEQUENCE_WIDTH  pattern; latched on accepted start
- repeat_n  in  REPEAT_W  number of passes; latched on accepted start; 0 is treated as 1
- hold  in  1  pause; no advance on an edge where it is 1
- A  out  1  first (earlier) bit of current pair = pattern bit 2i+1
- B  out  1  second bit of current pair = pattern bit 2i
- valid  out  1  A/B carry a new pair this cycle
- busy  out  1  transmission in progress
- done  out  1  one-cycle pulse after the last pair
- match_cnt  out  CNT_W  overlapping `01110` count over all emitted bits, saturating

## Operation
- States: IDLE, SEND.
- Reset values: state IDLE; A=0, B=0, valid=0, busy=0, done=0, match_cnt=0; shift register, pass counter and 4-bit history cleared.
- IDLE with start=1 at an edge:
  - latch seq_in and repeat_n
  - load pair 0 (seq_in[W-1:W-2]) onto A/B
  - valid=1, busy=1, match_cnt cleared, then updated for pair 0
  - go to SEND
- SEND, hold=0 at an edge: load the next pair. After pair W/2-1, wrap to pair 0 and decrement the pass counter.
- SEND, hold=1 at an edge: A/B held, valid=0, nothing counted; the following non-hold edge loads the next pair, not a repeat of the held one.
- After the last pair of the last pass, the next non-hold edge:
  - A=B=0, valid=0, busy=0
  - done=1 for one cycle
  - return to IDLE
- start in SEND is ignored. start on the same edge that produces done is ignored; the first start accepted is in the next IDLE cycle.
- Match counting:
  - bit order is A then B; history is the last 4 emitted bits and persists across pass boundaries
  - each loaded pair checks two windows, {hist[3:0],A} and {hist[2:0],A,B}; match_cnt adds 0, 1 or 2
  - saturates at 2^CNT_W−1
  - history is cleared on an accepted start; match_cnt holds its value in IDLE
- clr asserted mid-operation returns everything to reset values immediately; no done pulse.

## Timing
- Start-to-first-pair latency: pair 0 is on A/B after the edge that samples start.
- Throughput: 1 pair per non-hold cycle. Total busy cycles = max(repeat_n,1)·W/2 + number of hold edges.
- match_cnt is registered and includes the pair currently on A/B.
- done coincides with the busy falling edge.

## Structure
- Package `seq_gen_pkg`: state enum (IDLE, SEND) and constant MATCH_PAT = 5'b01110.
- One sub-module, `seq_match_cnt`: 4-bit history, two-window compare and saturating counter, with inputs load/A/B/clear.
- The top level holds the FSM, shift register and pass counter.

## Test plan
- seq_in = 24'b011101110111001110001110, repeat_n=1, hold=0 → pairs 01,11,01,11,01,11,00,11,10,00,11,10 on 12 consecutive cycles; done in the 13th cycle; match_cnt=5.
- Same pattern, repeat_n=2 → 24 pairs; match_cnt=10 (no match spans the pass boundary). repeat_n=0 → identical to repeat_n=1.
- seq_in all zeros, repeat_n=3 → 36 pairs of 00; match_cnt=0; busy high for exactly 36 cycles.
- hold=1 for 3 edges after pair 4 → A/B frozen, valid=0 for those 3 cycles; sequence resumes at pair 5; busy lasts 15 cycles; match_cnt still 5.
- start pulsed while busy and on the done edge → both ignored; a start in the next IDLE cycle launches a fresh transmission with match_cnt cleared.
- clr=1 at pair 6 → all outputs 0 immediately; a later start replays from pair 0 with match_cnt=5 at completion.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state type and match pattern for the 01110 pattern transmitter
package seq_gen_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [4:0] MATCH_PAT = 5'b01110;

endpackage

// File: rtl/seq_gen_01110_if.sv
// rtl/seq_gen_01110_if.sv - control and A/B symbol bus between stimulus logic and the transmitter
interface seq_gen_01110_if #(
    parameter int SEQUENCE_WIDTH = 24,
    parameter int REPEAT_W       = 4,
    parameter int CNT_W          = 8
);
    logic                      start;
    logic [SEQUENCE_WIDTH-1:0] seq_in;
    logic [REPEAT_W-1:0]       repeat_n;
    logic                      hold;
    logic                      A;
    logic                      B;
    logic                      valid;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          match_cnt;

    modport master (
        output start, seq_in, repeat_n, hold,
        input  A, B, valid, busy, done, match_cnt
    );

    modport slave (
        input  start, seq_in, repeat_n, hold,
        output A, B, valid, busy, done, match_cnt
    );
endinterface

// File: rtl/seq_match_cnt.sv
// rtl/seq_match_cnt.sv - golden overlapping 01110 counter over the emitted A-then-B bit stream
module seq_match_cnt
    import seq_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear,
    input  logic             load,
    input  logic             A,
    input  logic             B,
    output logic [CNT_W-1:0] count
);
    logic [3:0]       hist;
    logic [3:0]       hist_base;
    logic [CNT_W-1:0] cnt_base;
    logic             hit_a;
    logic             hit_b;
    logic [CNT_W:0]   sum;

    // A clear coincides with the load of pair 0, so the first pair counts from an empty history.
    always_comb begin
        hist_base = clear ? 4'b0000 : hist;
        cnt_base  = clear ? '0 : count;
        hit_a     = ({hist_base, A} == MATCH_PAT);
        hit_b     = ({hist_base[2:0], A, B} == MATCH_PAT);
        sum       = {1'b0, cnt_base} + {{CNT_W{1'b0}}, hit_a} + {{CNT_W{1'b0}}, hit_b};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist  <= 4'b0000;
            count <= '0;
        end else if (load) begin
            hist  <= {hist_base[1:0], A, B};
            count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (clear) begin
            hist  <= 4'b0000;
            count <= '0;
        end
    end
endmodule

// File: rtl/seq_gen_01110.sv
// rtl/seq_gen_01110.sv - emits a latched pattern as {A,B} pairs for a number of passes
module seq_gen_01110
    import seq_gen_pkg::*;
#(
    parameter int SEQUENCE_WIDTH = 24,
    parameter int REPEAT_W       = 4,
    parameter int CNT_W          = 8
) (
    input  logic            clk,
    input  logic            clr,
    seq_gen_01110_if.slave  bus
);
    localparam int W     = SEQUENCE_WIDTH;
    localparam int IDX_W = (W > 2) ? $clog2(W / 2) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W / 2 - 1);

    state_t              state;
    logic [W-1:0]        pat;
    logic [W-1:0]        sh;
    logic [REPEAT_W-1:0] pass_left;
    logic [IDX_W-1:0]    idx;
    logic                a_q;
    logic                b_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic accept;
    logic advance;
    logic last_pair;
    logic finish;
    logic load;
    logic next_a;
    logic next_b;

    always_comb begin
        accept    = (state == IDLE) && bus.start;
        advance   = (state == SEND) && !bus.hold;
        last_pair = (idx == LAST_IDX);
        finish    = advance && last_pair && (pass_left == REPEAT_W'(1));
        load      = accept || (advance && !finish);
        // sh already holds the pattern shifted past the pair on A/B; a wrap restarts from pat.
        if (accept) begin
            next_a = bus.seq_in[W-1];
            next_b = bus.seq_in[W-2];
        end else if (last_pair) begin
            next_a = pat[W-1];
            next_b = pat[W-2];
        end else begin
            next_a = sh[W-1];
            next_b = sh[W-2];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            pat       <= '0;
            sh        <= '0;
            pass_left <= '0;
            idx       <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (state == IDLE) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.start) begin
                pat       <= bus.seq_in;
                sh        <= bus.seq_in << 2;
                pass_left <= (bus.repeat_n == '0) ? REPEAT_W'(1) : bus.repeat_n;
                idx       <= '0;
                a_q       <= next_a;
                b_q       <= next_b;
                valid_q   <= 1'b1;
                busy_q    <= 1'b1;
                state     <= SEND;
            end
        end else begin
            done_q <= 1'b0;
            if (bus.hold) begin
                valid_q <= 1'b0;
            end else if (finish) begin
                a_q     <= 1'b0;
                b_q     <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state   <= IDLE;
            end else begin
                a_q     <= next_a;
                b_q     <= next_b;
                valid_q <= 1'b1;
                if (last_pair) begin
                    idx       <= '0;
                    sh        <= pat << 2;
                    pass_left <= pass_left - REPEAT_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                    sh  <= sh << 2;
                end
            end
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match (
        .clk   (clk),
        .clr   (clr),
        .clear (accept),
        .load  (load),
        .A     (next_a),
        .B     (next_b),
        .count (bus.match_cnt)
    );

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_gen_01110.sv
// tb/tb_seq_gen_01110.sv - directed self-checking bench for seq_gen_01110
module tb_seq_gen_01110;
    localparam logic [23:0] PAT = 24'b011101110111001110001110;
    localparam logic [1:0] EXP_PAIRS [12] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11,
                                              2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10};

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    seq_gen_01110_if #(.SEQUENCE_WIDTH(24), .REPEAT_W(4), .CNT_W(8)) bus ();

    seq_gen_01110 #(.SEQUENCE_WIDTH(24), .REPEAT_W(4), .CNT_W(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        clr = 1'b1;
        bus.start = 1'b0;
        bus.seq_in = '0;
        bus.repeat_n = '0;
        bus.hold = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.match_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL reset: got A=%b B=%b valid=%b busy=%b done=%b cnt=%0d, want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.match_cnt);
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Launches a transmission and checks every pair, optional 3-edge hold, done and match count.
    task automatic run_tx(input string name, input logic [23:0] pat, input logic [3:0] rep,
                          input int passes, input bit zero_pat, input int hold_at,
                          input int exp_match);
        int busy_cycles;
        logic [1:0] exp;
        int exp_busy;
        busy_cycles = 0;
        exp_busy = passes * 12 + ((hold_at >= 0) ? 3 : 0);
        bus.start = 1'b1;
        bus.seq_in = pat;
        bus.repeat_n = rep;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < passes * 12; k++) begin
            exp = zero_pat ? 2'b00 : EXP_PAIRS[k % 12];
            checks++;
            if ({bus.A, bus.B, bus.valid, bus.busy} !== {exp, 2'b11}) begin
                failures++;
                $display("FAIL %s pair %0d: got AB=%b%b valid=%b busy=%b, want AB=%b valid=1 busy=1",
                         name, k, bus.A, bus.B, bus.valid, bus.busy, exp);
            end
            if (bus.busy) busy_cycles++;
            if (!zero_pat && k == 2) begin
                checks++;
                if (bus.match_cnt !== 8'd1) begin
                    failures++;
                    $display("FAIL %s cnt at pair 2: got %0d want 1", name, bus.match_cnt);
                end
            end
            if (k == hold_at) begin
                bus.hold = 1'b1;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    checks++;
                    if ({bus.A, bus.B, bus.valid, bus.busy} !== {exp, 2'b01}) begin
                        failures++;
                        $display("FAIL %s hold %0d: got AB=%b%b valid=%b busy=%b, want AB=%b valid=0 busy=1",
                                 name, h, bus.A, bus.B, bus.valid, bus.busy, exp);
                    end
                    if (bus.busy) busy_cycles++;
                    if (h == 2) bus.hold = 1'b0;
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.A, bus.B, bus.valid, bus.busy, bus.done} !== 5'b00001 ||
            bus.match_cnt !== 8'(exp_match)) begin
            failures++;
            $display("FAIL %s end: got AB=%b%b valid=%b busy=%b done=%b cnt=%0d, want done=1 cnt=%0d",
                     name, bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.match_cnt, exp_match);
        end
        checks++;
        if (busy_cycles != exp_busy) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cycles, exp_busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.match_cnt !== 8'(exp_match)) begin
            failures++;
            $display("FAIL %s idle: got done=%b busy=%b cnt=%0d, want done=0 busy=0 cnt=%0d",
                     name, bus.done, bus.busy, bus.match_cnt, exp_match);
        end
    endtask

    task automatic test_basic();
        run_tx("basic", PAT, 4'd1, 1, 1'b0, -1, 5);
    endtask

    task automatic test_repeat();
        run_tx("repeat2", PAT, 4'd2, 2, 1'b0, -1, 10);
        run_tx("repeat0", PAT, 4'd0, 1, 1'b0, -1, 5);
    endtask

    task automatic test_zeros();
        run_tx("zeros", 24'd0, 4'd3, 3, 1'b1, -1, 0);
    endtask

    task automatic test_hold();
        run_tx("hold", PAT, 4'd1, 1, 1'b0, 4, 5);
    endtask

    task automatic test_start_ignored();
        bus.start = 1'b1;
        bus.seq_in = PAT;
        bus.repeat_n = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if ({bus.A, bus.B, bus.valid} !== {EXP_PAIRS[k], 1'b1}) begin
                failures++;
                $display("FAIL start_ign pair %0d: got AB=%b%b valid=%b want AB=%b valid=1",
                         k, bus.A, bus.B, bus.valid, EXP_PAIRS[k]);
            end
            if (k == 3) begin
                bus.start = 1'b1;
                bus.seq_in = 24'd0;
                bus.repeat_n = 4'd3;
            end else begin
                bus.start = (k == 11);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.match_cnt !== 8'd5) begin
            failures++;
            $display("FAIL start_ign done: got done=%b busy=%b cnt=%0d want 1 0 5",
                     bus.done, bus.busy, bus.match_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.match_cnt !== 8'd5) begin
            failures++;
            $display("FAIL start_ign after_done: got busy=%b valid=%b cnt=%0d want 0 0 5",
                     bus.busy, bus.valid, bus.match_cnt);
        end
        bus.start = 1'b1;
        bus.seq_in = PAT;
        bus.repeat_n = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.A, bus.B, bus.valid, bus.busy} !== 4'b0111 || bus.match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL start_ign relaunch: got AB=%b%b valid=%b busy=%b cnt=%0d want AB=01 1 1 cnt=0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.match_cnt);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.match_cnt !== 8'd5) begin
            failures++;
            $display("FAIL start_ign relaunch_end: got done=%b cnt=%0d want 1 5", bus.done, bus.match_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_clr_abort();
        bus.start = 1'b1;
        bus.seq_in = PAT;
        bus.repeat_n = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({bus.A, bus.B, bus.valid} !== {EXP_PAIRS[6], 1'b1}) begin
            failures++;
            $display("FAIL clr pair6: got AB=%b%b valid=%b want AB=%b valid=1",
                     bus.A, bus.B, bus.valid, EXP_PAIRS[6]);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.match_cnt} !== 13'd0) begin
            failures++;
            $display("FAIL clr immediate: got A=%b B=%b valid=%b busy=%b done=%b cnt=%0d want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.match_cnt);
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL clr no_done: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        run_tx("after_clr", PAT, 4'd1, 1, 1'b0, -1, 5);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_repeat();
        test_zeros();
        test_hold();
        test_start_ignored();
        test_clr_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
